// File: rtl/writeback_queue.sv
// writeback_queue: in-order load-result FIFO between memory writeback and the register-file write port.
// Optional WRITEBACK_QUEUE_BYPASS_EN adds a zero-latency pass-through when the queue is empty.
module writeback_queue #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int DEPTH           = 4
) (
    input  logic                        clk,
    input  logic                        sync_rst,
    input  logic                        clk_en,
    output logic                        Writeback_REQ,
    input  logic                        Writeback_ACK,
    input  logic [REGADDRBITWIDTH-1:0]  DestRegisterIn,
    input  logic [DATABITWIDTH-1:0]     DataIn,
    input  logic                        RegWrite_REQ,
    output logic                        RegWrite_ACK,
    output logic [REGADDRBITWIDTH-1:0]  DestRegisterOut,
    output logic [DATABITWIDTH-1:0]     DataOut,
    input  logic [REGADDRBITWIDTH-1:0]  QueryReg,
    output logic                        QueryPending,
    output logic [$clog2(DEPTH):0]      Occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REGADDRBITWIDTH-1:0] destMem [DEPTH];
    logic [DATABITWIDTH-1:0]    dataMem [DEPTH];
    logic [PW-1:0]              wrPtr, rdPtr;
    logic [CW-1:0]              count;
    logic                       empty, push, pop, enq, deq;

    assign empty         = count == '0;
    assign Writeback_REQ = (count != CW'(DEPTH)) && clk_en && !sync_rst;
    assign push          = Writeback_REQ && Writeback_ACK;
    assign pop           = RegWrite_ACK && RegWrite_REQ;
    assign Occupancy     = count;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming result straight to the write port.
    assign RegWrite_ACK    = empty ? Writeback_ACK && clk_en : clk_en && !sync_rst;
    assign DestRegisterOut = empty ? (Writeback_ACK ? DestRegisterIn : '0) : destMem[rdPtr];
    assign DataOut         = empty ? (Writeback_ACK ? DataIn : '0) : dataMem[rdPtr];
    assign enq             = push && !(empty && pop);
    assign deq             = pop && !empty;
`else
    assign RegWrite_ACK    = !empty && clk_en && !sync_rst;
    assign DestRegisterOut = empty ? '0 : destMem[rdPtr];
    assign DataOut         = empty ? '0 : dataMem[rdPtr];
    assign enq             = push;
    assign deq             = pop;
`endif

    always_comb begin
        QueryPending = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && destMem[rdPtr + PW'(i)] == QueryReg) QueryPending = 1'b1;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        if (Writeback_ACK && DestRegisterIn == QueryReg) QueryPending = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            destMem[wrPtr] <= DestRegisterIn;
            dataMem[wrPtr] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clk_en) begin
            if (enq) wrPtr <= wrPtr + 1'b1;
            if (deq) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end
endmodule
